bcd_tick_counter: RTL and testbench
===================================

# bcd_tick_counter

Downstream consumer of the frequency divider. Takes the divided clock (`clk_div6` or `clk_div`) as a level input sampled in the system clock domain. Counts its rising edges on a 2-digit BCD counter with wrap-around at a programmable terminal count (default 59, seconds-style). A start/stop/clear FSM gates counting; a one-cycle carry pulse feeds the next cascaded stage.

## Interface

Parameters:
- `MAX_TENS`, default 5: tens digit of the terminal count; legal range 0..9.
- `MAX_ONES`, default 9: ones digit of the terminal count; legal range 0..9.

Ports:
- `clk`, input, 1: system clock; all logic is on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `tick_in`, input, 1: divided clock from the divider, synchronous to `clk`; treated as a level.
- `start`, input, 1: level-sampled; request to count.
- `stop`, input, 1: level-sampled; request to hold.
- `clear`, input, 1: level-sampled; zero the count and return to IDLE.
- `ones`, output, 4: BCD ones digit, registered.
- `tens`, output, 4: BCD tens digit, registered.
- `carry`, output, 1: registered one-cycle pulse on wrap.
- `running`, output, 1: high while the FSM is in RUN.

## Operation

Edge detect:
- `tick_q` <= `tick_in` every cycle.
- `edge` = `tick_in & ~tick_q`.
- Reset loads `tick_q` = 1, so a `tick_in` that is already high at reset release is not counted. Exactly one count per rising edge, regardless of high-pulse width.

FSM states:
- IDLE (reset state): count is 00, no counting.
- RUN: counting.
- HOLD: count frozen.

FSM transitions, with priority clear > stop > start:
- `clear` in any state -> IDLE; count <= 00.
- RUN + `stop` -> HOLD.
- IDLE or HOLD + `start` -> RUN.
- Otherwise the state is unchanged.

Increment condition: current (registered) state is RUN, `edge` is 1, and both `clear` and `stop` are 0.
- A `start` in IDLE/HOLD in the same cycle as `edge` does not count; counting begins with the next edge.

Increment arithmetic:
- Terminal (`tens==MAX_TENS && ones==MAX_ONES`) -> count <= 00 and `carry` <= 1.
- Else if `ones==9` -> `ones` <= 0 and `tens` <= `tens`+1.
- Else `ones` <= `ones`+1.
- Digits never leave 0..9. Values 10..15 are unreachable.

`carry` is 0 in every cycle without a wrap.

`running` = (state == RUN), registered with the state.

Reset values: `ones`=0, `tens`=0, `carry`=0, `running`=0, state IDLE, `tick_q`=1.

## Timing

- `tick_in` is first seen high at clk edge k-1 (with `tick_q`=0). `ones`/`tens` update at edge k, one cycle after sampling.
- `carry` is high for exactly the cycle in which the count shows 00 after a wrap.
- FSM response: `start`/`stop`/`clear` sampled at edge k -> state and `running` change at edge k.
  - `clear` at edge k -> count 00 visible after edge k.
- Reset mid-operation: `rst` sampled high at edge k -> all outputs at reset values after edge k, regardless of other inputs. Resets overrides `clear`/`start`/`stop`/`edge`.
- Minimum `tick_in` period: 2 `clk` cycles (1 high, 1 low). The `clk_div6` 6-cycle period is fully supported.
- No combinational path from inputs to outputs.

## Test plan

1. Reset: hold `rst`=1 for 3 cycles with `tick_in`=1, then release with `tick_in` still high and `start`=1 -> `ones`=0, `tens`=0, `carry`=0, `running`=1; no count until `tick_in` falls and rises again.
2. Basic count: `start` pulse, then 10 `tick_in` rising edges at 6-cycle period -> `tens`=1, `ones`=0. Each update occurs one cycle after sampled high, and exactly once per rising edge.
3. Wrap: 60 edges from 00 with default params -> sequence 58, 59, 00; `carry` high exactly one cycle, concurrent with 00; total carry count 1. With `MAX_TENS`=2, `MAX_ONES`=3: 23 -> 00 with carry.
4. Hold/resume: run to 25, assert `stop`, apply 5 edges -> stays 25, `running`=0. Assert `start`, next edge -> 26.
5. Simultaneous events:
   - `clear`+`start`+`edge` in the same cycle at count 14 -> count 00, state IDLE.
   - `stop`+`edge` in RUN at 30 -> stays 30, HOLD.
   - `start`+`edge` in IDLE -> stays 00, RUN.
6. Reset mid-run at count 37 with `edge` in the same cycle -> next cycle all outputs at reset values, state IDLE, `carry`=0.

Source files
------------

// File: rtl/bcd_tick_counter.sv
// Two-digit BCD counter of rising edges on a divided-clock level input.
// A start/stop/clear FSM gates counting; the count wraps to 00 after the
// terminal value MAX_TENS:MAX_ONES and raises a one-cycle carry for the
// next cascaded stage. All outputs are registered.
module bcd_tick_counter #(
   parameter int unsigned MAX_TENS = 5,
   parameter int unsigned MAX_ONES = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_in,
   input  logic       start,
   input  logic       stop,
   input  logic       clear,
   output logic [3:0] ones,
   output logic [3:0] tens,
   output logic       carry,
   output logic       running
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   localparam logic [3:0] TERM_TENS = 4'(MAX_TENS);
   localparam logic [3:0] TERM_ONES = 4'(MAX_ONES);

   logic [1:0] state_reg, state_next;
   logic       tick_q_reg;
   logic       edge_reg;
   logic [3:0] ones_reg, ones_next;
   logic [3:0] tens_reg, tens_next;
   logic       carry_reg, carry_next;
   logic       running_reg;
   logic       count_en;
   logic       at_terminal;

   // Rising-edge detector on the tick level; the detected edge is registered
   // so the count updates one cycle after tick_in is first sampled high.
   // tick_q resets high so a tick already high at reset release is ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_q_reg <= 1'b1;
         edge_reg   <= 1'b0;
      end else begin
         tick_q_reg <= tick_in;
         edge_reg   <= tick_in & ~tick_q_reg;
      end
   end

   // FSM next state: clear beats stop beats start.
   always_comb begin
      state_next = state_reg;
      if (clear) begin
         state_next = ST_IDLE;
      end else if (stop) begin
         if (state_reg == ST_RUN) begin
            state_next = ST_HOLD;
         end
      end else if (start) begin
         if (state_reg == ST_IDLE || state_reg == ST_HOLD) begin
            state_next = ST_RUN;
         end
      end
   end

   // Counting only from an already-running state, so a start arriving with
   // an edge does not count that edge.
   assign count_en    = (state_reg == ST_RUN) && edge_reg && !clear && !stop;
   assign at_terminal = (tens_reg == TERM_TENS) && (ones_reg == TERM_ONES);

   // BCD increment with wrap at the terminal count; clear zeroes the count.
   always_comb begin
      ones_next  = ones_reg;
      tens_next  = tens_reg;
      carry_next = 1'b0;
      if (clear) begin
         ones_next = 4'd0;
         tens_next = 4'd0;
      end else if (count_en) begin
         if (at_terminal) begin
            ones_next  = 4'd0;
            tens_next  = 4'd0;
            carry_next = 1'b1;
         end else if (ones_reg == 4'd9) begin
            ones_next = 4'd0;
            tens_next = (tens_reg == 4'd9) ? 4'd0 : tens_reg + 4'd1;
         end else begin
            ones_next = ones_reg + 4'd1;
         end
      end
   end

   // State, count, carry and running flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= ST_IDLE;
         ones_reg    <= 4'd0;
         tens_reg    <= 4'd0;
         carry_reg   <= 1'b0;
         running_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         ones_reg    <= ones_next;
         tens_reg    <= tens_next;
         carry_reg   <= carry_next;
         running_reg <= (state_next == ST_RUN);
      end
   end

   assign ones    = ones_reg;
   assign tens    = tens_reg;
   assign carry   = carry_reg;
   assign running = running_reg;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Directed bench for bcd_tick_counter: default instance (wrap at 59) and a
// second instance wrapping at 23, both driven by the same stimulus.
module tb_bcd_tick_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick_in = 1'b1;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       clear = 1'b0;
   logic [3:0] ones_a, tens_a, ones_b, tens_b;
   logic       carry_a, running_a, carry_b, running_b;

   int n_cmp = 0;
   int n_err = 0;
   int carry_cnt = 0;

   typedef struct {
      string      tag;
      bit         sel23;
      logic [3:0] ones;
      logic [3:0] tens;
      logic       carry;
      logic       running;
   } exp_t;

   exp_t sb_q[$];

   always #5 clk = ~clk;

   bcd_tick_counter dut (
      .clk(clk), .rst(rst), .tick_in(tick_in), .start(start), .stop(stop),
      .clear(clear), .ones(ones_a), .tens(tens_a), .carry(carry_a),
      .running(running_a)
   );

   bcd_tick_counter #(.MAX_TENS(2), .MAX_ONES(3)) dut23 (
      .clk(clk), .rst(rst), .tick_in(tick_in), .start(start), .stop(stop),
      .clear(clear), .ones(ones_b), .tens(tens_b), .carry(carry_b),
      .running(running_b)
   );

   // Count carry pulses of the default instance.
   always @(posedge clk) begin
      if (carry_a === 1'b1) carry_cnt <= carry_cnt + 1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout, required finish");
      $fatal(1, "watchdog");
   end

   function automatic void cmp(string tag, logic [7:0] obs, logic [7:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0d required %0d", tag, obs, expv);
      end
   endfunction

   task automatic check_sb();
      exp_t e;
      logic [3:0] o, t;
      logic c, r;
      e = sb_q.pop_front();
      if (e.sel23) begin
         o = ones_b; t = tens_b; c = carry_b; r = running_b;
      end else begin
         o = ones_a; t = tens_a; c = carry_a; r = running_a;
      end
      $display("step %s: count=%0d%0d carry=%0b running=%0b", e.tag, t, o, c, r);
      cmp({e.tag, ".ones"}, {4'd0, o}, {4'd0, e.ones});
      cmp({e.tag, ".tens"}, {4'd0, t}, {4'd0, e.tens});
      cmp({e.tag, ".carry"}, {7'd0, c}, {7'd0, e.carry});
      cmp({e.tag, ".running"}, {7'd0, r}, {7'd0, e.running});
   endtask

   task automatic expect_out(string tag, bit sel23, int val, logic c, logic r);
      exp_t e;
      e.tag = tag; e.sel23 = sel23;
      e.ones = 4'(val % 10); e.tens = 4'(val / 10);
      e.carry = c; e.running = r;
      sb_q.push_back(e);
      check_sb();
   endtask

   task automatic cyc(input logic t, input logic s, input logic p,
                      input logic c, input logic r);
      tick_in = t; start = s; stop = p; clear = c; rst = r;
      @(posedge clk);
      #1;
   endtask

   // n tick periods of 6 cycles (3 high, 3 low), control inputs idle.
   task automatic pulse(input int n);
      repeat (n) begin
         repeat (3) cyc(1, 0, 0, 0, 0);
         repeat (3) cyc(0, 0, 0, 0, 0);
      end
   endtask

   task automatic restart();
      cyc(0, 0, 0, 1, 0);
      cyc(0, 1, 0, 0, 0);
   endtask

   initial begin
      int c0;
      // Reset with tick high, release with start and tick still high
      repeat (3) cyc(1, 0, 0, 0, 1);
      expect_out("reset", 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0);
      expect_out("release_start", 0, 0, 0, 1);
      repeat (3) cyc(1, 0, 0, 0, 0);
      expect_out("held_high_no_count", 0, 0, 0, 1);
      repeat (3) cyc(0, 0, 0, 0, 0);
      expect_out("tick_low", 0, 0, 0, 1);

      // Basic count with one-cycle latency and one count per edge
      cyc(1, 0, 0, 0, 0);
      expect_out("latency_first_cycle", 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 0);
      expect_out("latency_update", 0, 1, 0, 1);
      cyc(1, 0, 0, 0, 0);
      expect_out("wide_pulse_once", 0, 1, 0, 1);
      repeat (3) cyc(0, 0, 0, 0, 0);
      pulse(4);
      expect_out("count5", 0, 5, 0, 1);
      pulse(5);
      expect_out("count10", 0, 10, 0, 1);

      // Wrap at 23 on the second instance
      restart();
      expect_out("restart23", 1, 0, 0, 1);
      pulse(23);
      expect_out("w23_at23", 1, 23, 0, 1);
      cyc(1, 0, 0, 0, 0);
      expect_out("w23_pre", 1, 23, 0, 1);
      cyc(1, 0, 0, 0, 0);
      expect_out("w23_wrap", 1, 0, 1, 1);
      cyc(1, 0, 0, 0, 0);
      expect_out("w23_after", 1, 0, 0, 1);
      repeat (3) cyc(0, 0, 0, 0, 0);

      // Wrap at 59 on the default instance
      restart();
      c0 = carry_cnt;
      pulse(58);
      expect_out("w59_at58", 0, 58, 0, 1);
      pulse(1);
      expect_out("w59_at59", 0, 59, 0, 1);
      cyc(1, 0, 0, 0, 0);
      expect_out("w59_pre", 0, 59, 0, 1);
      cyc(1, 0, 0, 0, 0);
      expect_out("w59_wrap", 0, 0, 1, 1);
      cyc(1, 0, 0, 0, 0);
      expect_out("w59_after", 0, 0, 0, 1);
      repeat (3) cyc(0, 0, 0, 0, 0);
      cmp("carry_total", 8'(carry_cnt - c0), 8'd1);

      // Hold and resume
      restart();
      pulse(25);
      expect_out("hold_at25", 0, 25, 0, 1);
      cyc(0, 0, 1, 0, 0);
      expect_out("hold_stop", 0, 25, 0, 0);
      pulse(5);
      expect_out("hold_frozen", 0, 25, 0, 0);
      cyc(0, 1, 0, 0, 0);
      expect_out("hold_resume", 0, 25, 0, 1);
      pulse(1);
      expect_out("hold_26", 0, 26, 0, 1);

      // clear+start+edge at 14
      restart();
      pulse(14);
      expect_out("sim_at14", 0, 14, 0, 1);
      cyc(1, 0, 0, 0, 0);
      cyc(1, 1, 0, 1, 0);
      expect_out("sim_clear_edge", 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      repeat (3) cyc(0, 0, 0, 0, 0);
      expect_out("sim_idle", 0, 0, 0, 0);

      // start+edge in IDLE does not count that edge
      cyc(1, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0);
      expect_out("sim_start_edge", 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 0);
      repeat (3) cyc(0, 0, 0, 0, 0);
      expect_out("sim_start_no_count", 0, 0, 0, 1);
      pulse(1);
      expect_out("sim_next_edge", 0, 1, 0, 1);

      // stop+edge in RUN at 30
      restart();
      pulse(30);
      expect_out("sim_at30", 0, 30, 0, 1);
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 1, 0, 0);
      expect_out("sim_stop_edge", 0, 30, 0, 0);
      cyc(1, 0, 0, 0, 0);
      repeat (3) cyc(0, 0, 0, 0, 0);
      pulse(1);
      expect_out("sim_hold30", 0, 30, 0, 0);

      // Reset mid-run at 37 with an edge pending
      restart();
      pulse(37);
      expect_out("rst_at37", 0, 37, 0, 1);
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 1);
      expect_out("rst_mid", 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      repeat (3) cyc(0, 0, 0, 0, 0);
      pulse(1);
      expect_out("rst_idle", 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
